// File: rtl/mul_pkg.sv
// Shared types for the shift-free repeated-addition multiplier: FSM states,
// control-word struct and the default operand width.
package mul_pkg;

  localparam int unsigned WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    MULT,
    DONE
  } state_t;

  typedef struct packed {
    logic ldA;
    logic ldB;
    logic ldP;
    logic clrP;
    logic decB;
    logic done;
  } ctl_t;

  // Moore control word asserted while sitting in state s.
  function automatic ctl_t ctl_for(state_t s);
    ctl_t c;
    c = '0;
    case (s)
      LOAD_A: c.ldA = 1'b1;
      LOAD_B: begin
        c.ldB  = 1'b1;
        c.clrP = 1'b1;
      end
      MULT: begin
        c.ldP  = 1'b1;
        c.decB = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mul_if.sv
// Operand/result bus of the multiplier. The ovf signal exists only when
// MUL_OVF_EN is defined.
interface mul_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data_in;
  logic             done;
  logic [WIDTH-1:0] product;
`ifdef MUL_OVF_EN
  logic             ovf;

  modport master (output start, output data_in, input done, input product, input ovf);
  modport slave  (input start, input data_in, output done, output product, output ovf);
`else
  modport master (output start, output data_in, input done, input product);
  modport slave  (input start, input data_in, output done, output product);
`endif
endinterface

// File: rtl/mul_controller.sv
// Five-state Moore controller for the multiplier; every control output is
// registered alongside the state it belongs to.
module mul_controller
  import mul_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic eqz,
  output logic ldA,
  output logic ldB,
  output logic ldP,
  output logic clrP,
  output logic decB,
  output logic done
);

  state_t state;
  ctl_t   ctl;

  // Outputs are loaded with the control word of the state being entered,
  // so they change on the same edge as the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ctl   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD_A;
            ctl   <= ctl_for(LOAD_A);
          end else begin
            state <= IDLE;
            ctl   <= ctl_for(IDLE);
          end
        end
        LOAD_A: begin
          state <= LOAD_B;
          ctl   <= ctl_for(LOAD_B);
        end
        LOAD_B: begin
          state <= MULT;
          ctl   <= ctl_for(MULT);
        end
        MULT: begin
          if (eqz) begin
            state <= DONE;
            ctl   <= ctl_for(DONE);
          end else begin
            state <= MULT;
            ctl   <= ctl_for(MULT);
          end
        end
        DONE: begin
          if (start) begin
            state <= DONE;
            ctl   <= ctl_for(DONE);
          end else begin
            state <= IDLE;
            ctl   <= ctl_for(IDLE);
          end
        end
        default: begin
          state <= IDLE;
          ctl   <= '0;
        end
      endcase
    end
  end

  assign ldA  = ctl.ldA;
  assign ldB  = ctl.ldB;
  assign ldP  = ctl.ldP;
  assign clrP = ctl.clrP;
  assign decB = ctl.decB;
  assign done = ctl.done;

endmodule

// File: rtl/mul_datapath.sv
// Repeated-addition multiplier: A/B/P registers and adder driven by
// mul_controller. Optional sticky overflow flag under MUL_OVF_EN.
module mul_datapath
  import mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input logic  clk,
  input logic  rst,
  mul_if.slave bus
);

  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] P;
  logic             eqz;
  logic             ldA, ldB, ldP, clrP, decB, done;

  assign eqz = (B == '0);

  mul_controller u_ctrl (
    .clk   (clk),
    .rst   (rst),
    .start (bus.start),
    .eqz   (eqz),
    .ldA   (ldA),
    .ldB   (ldB),
    .ldP   (ldP),
    .clrP  (clrP),
    .decB  (decB),
    .done  (done)
  );

`ifdef MUL_OVF_EN
  logic [WIDTH:0] sum;
  logic           ovf;
  assign sum = {1'b0, P} + {1'b0, A};
`else
  logic [WIDTH-1:0] sum;
  assign sum = P + A;
`endif

  // ldP/decB are Moore (asserted for all of MULT); the final MULT cycle,
  // where B has reached zero, must leave P and B untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      A <= '0;
      B <= '0;
      P <= '0;
    end else begin
      if (ldA) A <= bus.data_in;
      if (ldB) B <= bus.data_in;
      else if (decB && !eqz) B <= B - WIDTH'(1);
      if (clrP) P <= '0;
      else if (ldP && !eqz) P <= sum[WIDTH-1:0];
    end
  end

`ifdef MUL_OVF_EN
  always_ff @(posedge clk) begin
    if (rst || clrP) ovf <= 1'b0;
    else if (ldP && !eqz && sum[WIDTH]) ovf <= 1'b1;
  end
  assign bus.ovf = ovf;
`endif

  assign bus.done    = done;
  assign bus.product = P;

endmodule

// File: tb/tb_mul_datapath.sv
// Directed bench for mul_datapath: vector table of operand pairs plus
// mid-MULT reset and start-held-through-DONE sequences.
module tb_mul_datapath;

  logic clk = 1'b0;
  logic rst;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  mul_if #(.WIDTH(16)) bus ();

  mul_datapath #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    int unsigned lat;
    bit          ovf;
    bit          hold;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t v);
    int unsigned n;
    bit          seen;
    logic [15:0] held;
    seen = 1'b0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = 16'($urandom);
    @(posedge clk);  // edge 0: start sampled in IDLE
    for (n = 1; n <= v.lat + 20; n++) begin
      @(negedge clk);
      bus.start   = v.hold || (n == 4 && v.b >= 2);
      bus.data_in = (n == 1) ? v.a : (n == 2) ? v.b : 16'($urandom);
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    check("latency", seen ? n : 0, v.lat);
    check("product", 32'(bus.product), 32'(v.p));
`ifdef MUL_OVF_EN
    check("ovf", 32'(bus.ovf), 32'(v.ovf));
`endif
    held = bus.product;
    if (v.hold) begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        check("hold_done", 32'(bus.done), 32'd1);
        check("hold_product", 32'(bus.product), 32'(held));
      end
    end
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("done_drop", 32'(bus.done), 32'd0);
    check("product_stable", 32'(bus.product), 32'(v.p));
  endtask

  initial begin
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.data_in = '0;

    vecs[0] = '{a: 16'd17,    b: 16'd5,   p: 16'd85,    lat: 8,   ovf: 1'b0, hold: 1'b0};
    vecs[1] = '{a: 16'd9,     b: 16'd0,   p: 16'd0,     lat: 3,   ovf: 1'b0, hold: 1'b0};
    vecs[2] = '{a: 16'd0,     b: 16'd100, p: 16'd0,     lat: 103, ovf: 1'b0, hold: 1'b0};
    vecs[3] = '{a: 16'd300,   b: 16'd300, p: 16'd24464, lat: 303, ovf: 1'b1, hold: 1'b0};
    vecs[4] = '{a: 16'd65535, b: 16'd2,   p: 16'd65534, lat: 5,   ovf: 1'b1, hold: 1'b0};
    vecs[5] = '{a: 16'd4096,  b: 16'd16,  p: 16'd0,     lat: 19,  ovf: 1'b1, hold: 1'b0};
    vecs[6] = '{a: 16'd3,     b: 16'd4,   p: 16'd12,    lat: 7,   ovf: 1'b0, hold: 1'b1};
    vecs[7] = '{a: 16'd6,     b: 16'd7,   p: 16'd42,    lat: 10,  ovf: 1'b0, hold: 1'b0};

    repeat (2) @(posedge clk);
    #1;
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_product", 32'(bus.product), 32'd0);
`ifdef MUL_OVF_EN
    check("reset_ovf", 32'(bus.ovf), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_op(vecs[i]);

    // Abort 7*50 after eight MULT iterations.
    @(negedge clk);
    bus.start   = 1'b1;
    bus.data_in = '0;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      bus.start   = 1'b0;
      bus.data_in = (n == 1) ? 16'd7 : (n == 2) ? 16'd50 : 16'hBEEF;
      @(posedge clk);
    end
    #1;
    check("pre_rst_product", 32'(bus.product), 32'd56);
    check("pre_rst_done", 32'(bus.done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_done", 32'(bus.done), 32'd0);
    check("mid_rst_product", 32'(bus.product), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    check("post_rst_idle_done", 32'(bus.done), 32'd0);
    check("post_rst_idle_product", 32'(bus.product), 32'd0);
    run_op(vecs[0]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_datapath.md
MUL_DATAPATH -- requirements
Module: mul_datapath

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the operand, product and counter width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: level request for a multiplication, sampled only in IDLE.
REQ-005 The block SHALL have port data_in, input, WIDTH bits: shared operand bus; carries A during LOAD_A and B during LOAD_B.
REQ-006 The block SHALL have port done, output, 1 bit: high exactly while in DONE.
REQ-007 The block SHALL have port product, output, WIDTH bits: direct view of the P register.

Function
REQ-008 Datapath registers SHALL be A, B and P, each WIDTH bits; eqz SHALL be combinational (B == 0).
REQ-009 The FSM SHALL have states IDLE, LOAD_A, LOAD_B, MULT and DONE, with Moore outputs.
REQ-010 IDLE SHALL go to LOAD_A when start=1 and otherwise stay in IDLE.
REQ-011 LOAD_A SHALL load A from data_in and always go to LOAD_B.
REQ-012 LOAD_B SHALL load B from data_in, clear P, and always go to MULT.
REQ-013 MULT with eqz=0 SHALL set P <= P + A and B <= B - 1, and stay in MULT.
REQ-014 MULT with eqz=1 SHALL leave P and B unchanged and go to DONE.
REQ-015 DONE SHALL hold P and go to IDLE when start=0; it SHALL stay in DONE while start=1.
REQ-016 The product SHALL equal (A*B) mod 2^WIDTH: the addition wraps and B never underflows.
REQ-017 Latency: with the start-sampling edge as edge 0, done SHALL rise after edge B+3, so B=0 gives 3 cycles.
REQ-018 start changes outside IDLE and DONE SHALL be ignored.
REQ-019 data_in SHALL be ignored outside LOAD_A and LOAD_B.
REQ-020 product SHALL remain valid and stable from DONE entry until the next LOAD_B.

Reset
REQ-021 rst=1 at a rising clk edge SHALL force IDLE and clear A, B and P to 0, so done=0 and product=0.
REQ-022 rst SHALL take priority over every transition, including mid-MULT, and abort the operation without producing done.

Configuration
REQ-023 With macro MUL_OVF_EN defined, the block SHALL add output port ovf (1 bit).
REQ-024 ovf SHALL be cleared in LOAD_B and on reset, and set sticky on any carry out of P + A in MULT.
REQ-025 Without MUL_OVF_EN, the ovf port and its logic SHALL be absent, and wrap-around SHALL be silent.

Structure
REQ-026 A shared package mul_pkg SHALL hold the state enumeration type and the default WIDTH constant.
REQ-027 The FSM SHALL be the sub-module mul_controller.
REQ-028 mul_controller inputs SHALL be clk, rst, start and eqz.
REQ-029 mul_controller outputs SHALL be ldA, ldB, ldP, clrP, decB and done; the registers and adder SHALL live in mul_datapath.

Verification
REQ-030 Bench SHALL check: reset, then start=1 with data_in=17 in LOAD_A and 5 in LOAD_B -> product=85, done after 8 cycles.
REQ-031 Bench SHALL check: A=9, B=0 -> product=0, done 3 cycles after start is sampled.
REQ-032 Bench SHALL check: A=0, B=100 -> product=0, done after 103 cycles.
REQ-033 Bench SHALL check: A=300, B=300 -> product=90000 mod 65536 = 24464; with MUL_OVF_EN, ovf=1.
REQ-034 Bench SHALL check: rst=1 asserted mid-MULT -> next cycle IDLE, product=0, done=0; a new run 17*5 still yields 85.
REQ-035 Bench SHALL check: start held high through DONE -> done stays 1; start=0 -> IDLE next cycle; start=1 again -> new operation.
